// File: rtl/action_selector_if.sv
// -----------------------------------------------------------------------------
// action_selector_if
// Bundles the request, Q-table read and action result signals of the action
// selector into one interface.
//   slave  : the action selector itself (consumes start/state/epsilon and
//            Q-table read data; produces the read strobe/address and result)
//   master : the environment (requester plus Q-table memory)
// Signals:
//   start, current_state[5:0], epsilon[7:0]   request side
//   q_rd_en, q_rd_addr[7:0], q_rd_data        Q-table read port
//   next_action[3:0], action_valid, explored  result
//   busy                                      high whenever not idle
// -----------------------------------------------------------------------------
interface action_selector_if #(
  parameter int Q_WIDTH = 16
);
  logic                      start;
  logic [5:0]                current_state;
  logic [7:0]                epsilon;
  logic                      q_rd_en;
  logic [7:0]                q_rd_addr;
  logic signed [Q_WIDTH-1:0] q_rd_data;
  logic [3:0]                next_action;
  logic                      action_valid;
  logic                      explored;
  logic                      busy;

  modport master (
    output start, current_state, epsilon, q_rd_data,
    input  q_rd_en, q_rd_addr, next_action, action_valid, explored, busy
  );

  modport slave (
    input  start, current_state, epsilon, q_rd_data,
    output q_rd_en, q_rd_addr, next_action, action_valid, explored, busy
  );
endinterface

// File: rtl/action_selector.sv
// -----------------------------------------------------------------------------
// action_selector
// Epsilon-greedy action picker for a 64-state maze agent. On start it reads the
// four Q-values of the latched state, keeps a signed running maximum (ties go
// to the lowest action index) and then either takes the greedy argmax or, with
// probability epsilon/256, a random action drawn from a free-running LFSR.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : action_selector_if.slave (request, Q-table read port, result)
// Timing: start sampled in IDLE -> READ x4 -> WAIT -> DECIDE -> IDLE;
//   action_valid pulses in the cycle after DECIDE, i.e. on the 7th edge
//   counting the edge that sampled start.
// -----------------------------------------------------------------------------
module action_selector #(
  parameter int          Q_WIDTH   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  action_selector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WAIT   = 2'd2,
    DECIDE = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [5:0]                st_q, st_d;          // latched maze state
  logic [1:0]                idx_q, idx_d;        // action index being read
  logic                      rd_pend_q, rd_pend_d; // data returns this cycle
  logic [1:0]                rd_idx_q, rd_idx_d;  // index of returning data
  logic signed [Q_WIDTH-1:0] max_q, max_d;
  logic [1:0]                arg_q, arg_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [3:0]                act_q, act_d;
  logic                      expl_q, expl_d;
  logic                      valid_q, valid_d;

  logic                      rd_en;
  logic [7:0]                rd_addr;
  logic signed [Q_WIDTH-1:0] rd_data;

  assign rd_data = bus.q_rd_data;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    idx_d     = idx_q;
    rd_pend_d = 1'b0;
    rd_idx_d  = idx_q;
    max_d     = max_q;
    arg_d     = arg_q;
    act_d     = act_q;
    expl_d    = expl_q;
    valid_d   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = 8'h00;

    // Fibonacci LFSR, taps 16,14,13,11; runs in every state.
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Q-data arrives one cycle after its read strobe. Index 0 seeds the
    // maximum; later values must be strictly greater, so ties keep the
    // lowest index.
    if (rd_pend_q && ((rd_idx_q == 2'd0) || (rd_data > max_q))) begin
      max_d = rd_data;
      arg_d = rd_idx_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = bus.current_state;
          idx_d   = 2'd0;
          state_d = READ;
        end
      end
      READ: begin
        rd_en     = 1'b1;
        rd_addr   = {st_q, idx_q};
        rd_pend_d = 1'b1;
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = WAIT;
      end
      WAIT: begin
        // Fourth read returns here; the maximum is final by DECIDE.
        state_d = DECIDE;
      end
      DECIDE: begin
        if (lfsr_q[7:0] < bus.epsilon) begin
          act_d  = 4'b0001 << lfsr_q[9:8];
          expl_d = 1'b1;
        end else begin
          act_d  = 4'b0001 << arg_q;
          expl_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values computed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= 6'd0;
      idx_q     <= 2'd0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= 2'd0;
      max_q     <= '0;
      arg_q     <= 2'd0;
      lfsr_q    <= LFSR_SEED;
      act_q     <= 4'b0000;
      expl_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      idx_q     <= idx_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
      max_q     <= max_d;
      arg_q     <= arg_d;
      lfsr_q    <= lfsr_d;
      act_q     <= act_d;
      expl_q    <= expl_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.q_rd_en      = rd_en;
  assign bus.q_rd_addr    = rd_addr;
  assign bus.next_action  = act_q;
  assign bus.explored     = expl_q;
  assign bus.action_valid = valid_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_action_selector.sv
// -----------------------------------------------------------------------------
// tb_action_selector
// Directed bench for action_selector: a Q-table memory model answers reads one
// cycle later, a reference LFSR runs alongside the DUT, and each request's
// expected action is pushed to a scoreboard queue when start is driven and
// popped when action_valid appears.
// -----------------------------------------------------------------------------
module tb_action_selector;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [3:0] act;
    logic       expl;
  } exp_t;

  logic clk;
  logic rst;

  action_selector_if #(.Q_WIDTH(16)) bus ();

  action_selector #(.Q_WIDTH(16), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic signed [15:0] qmem [256];
  logic [15:0]        lfsr_m;
  exp_t               sb [$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Q-table memory: data for a read strobe is returned on the next cycle.
  always @(posedge clk) begin
    bus.q_rd_data <= bus.q_rd_en ? qmem[bus.q_rd_addr] : 16'sd0;
  end

  // Reference LFSR tracking the DUT's free-running generator.
  always @(posedge clk) begin
    lfsr_m <= rst ? SEED : lfsr_step(lfsr_m);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // l0 is the LFSR value in the cycle start is sampled; the DECIDE cycle
  // comes six edges later.
  function automatic exp_t predict(input logic [15:0] l0, input logic [5:0] st,
                                   input logic [7:0] eps);
    exp_t               e;
    logic [15:0]        l;
    logic signed [15:0] best;
    logic [1:0]         bi;
    l = l0;
    for (int i = 0; i < 6; i++) l = lfsr_step(l);
    best = qmem[{st, 2'd0}];
    bi   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (qmem[{st, 2'(i)}] > best) begin
        best = qmem[{st, 2'(i)}];
        bi   = 2'(i);
      end
    end
    if (l[7:0] < eps) begin
      e.act  = 4'b0001 << l[9:8];
      e.expl = 1'b1;
    end else begin
      e.act  = 4'b0001 << bi;
      e.expl = 1'b0;
    end
    return e;
  endfunction

  // One request; optionally changes current_state one cycle after start.
  task automatic run_req(input logic [5:0] st, input logic [7:0] eps,
                         input bit change, input logic [5:0] st_after,
                         input string tag);
    int         got_k;
    int         n_rd;
    logic [7:0] addrs [4];
    int         ks [4];
    bit         addr_bad;
    exp_t       e;
    got_k    = 0;
    n_rd     = 0;
    addr_bad = 1'b0;
    @(negedge clk);
    bus.start         = 1'b1;
    bus.current_state = st;
    bus.epsilon       = eps;
    sb.push_back(predict(lfsr_m, st, eps));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        if (change) bus.current_state = st_after;
      end
      if (bus.q_rd_en) begin
        if (n_rd < 4) begin
          addrs[n_rd] = bus.q_rd_addr;
          ks[n_rd]    = k;
        end
        n_rd++;
      end else if (bus.q_rd_addr !== 8'h00) begin
        addr_bad = 1'b1;
      end
      if (bus.action_valid) begin
        got_k = k;
        break;
      end
    end
    check({tag, " latency"}, 32'(got_k), 32'd7);
    check({tag, " reads"}, 32'(n_rd), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_rd) begin
        check($sformatf("%s addr%0d", tag, i), 32'(addrs[i]), 32'({st, 2'(i)}));
        check($sformatf("%s rdcyc%0d", tag, i), 32'(ks[i]), 32'(i + 1));
      end
    end
    check({tag, " addr0_when_idle"}, 32'(addr_bad), 32'd0);
    e = sb.pop_front();
    check({tag, " action"}, 32'(bus.next_action), 32'(e.act));
    check({tag, " explored"}, 32'(bus.explored), 32'(e.expl));
    @(posedge clk);
    @(negedge clk);
    check({tag, " valid_one_cycle"}, 32'(bus.action_valid), 32'd0);
    check({tag, " action_held"}, 32'(bus.next_action), 32'(e.act));
  endtask

  initial begin
    int nv;
    int bad;

    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.current_state = 6'd0;
    bus.epsilon       = 8'd0;
    for (int i = 0; i < 256; i++) qmem[i] = 16'($urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst next_action", 32'(bus.next_action), 32'd0);
    check("rst action_valid", 32'(bus.action_valid), 32'd0);
    check("rst explored", 32'(bus.explored), 32'd0);
    check("rst q_rd_en", 32'(bus.q_rd_en), 32'd0);
    check("rst q_rd_addr", 32'(bus.q_rd_addr), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Greedy pick: Q {10,-3,40,7} at state 5 -> action 2.
    qmem[8'h14] = 16'sd10;
    qmem[8'h15] = -16'sd3;
    qmem[8'h16] = 16'sd40;
    qmem[8'h17] = 16'sd7;
    run_req(6'd5, 8'd0, 1'b0, 6'd0, "greedy");
    check("greedy onehot", 32'(bus.next_action), 32'h4);

    // Signed tie: {-5,-5,-9,-5} -> lowest index wins.
    qmem[{6'd12, 2'd0}] = -16'sd5;
    qmem[{6'd12, 2'd1}] = -16'sd5;
    qmem[{6'd12, 2'd2}] = -16'sd9;
    qmem[{6'd12, 2'd3}] = -16'sd5;
    run_req(6'd12, 8'd0, 1'b0, 6'd0, "tie");
    check("tie onehot", 32'(bus.next_action), 32'h1);

    // current_state 5 -> 9 after the latch edge must not alter addresses.
    qmem[{6'd5, 2'd3}] = 16'sd100;
    for (int i = 0; i < 4; i++) qmem[{6'd9, 2'(i)}] = (i == 1) ? 16'sd500 : -16'sd500;
    run_req(6'd5, 8'd0, 1'b1, 6'd9, "latch");
    check("latch onehot", 32'(bus.next_action), 32'h8);

    // start held high: one action per 7 cycles, busy low only when idle.
    @(negedge clk);
    bus.start         = 1'b1;
    bus.current_state = 6'd3;
    bus.epsilon       = 8'd0;
    nv  = 0;
    bad = 0;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.action_valid) begin
        nv++;
        if (k % 7 != 0) bad++;
      end
      if (bus.busy === bus.action_valid) bad++;
    end
    bus.start = 1'b0;
    check("held valid_count", 32'(nv), 32'd4);
    check("held spacing_busy", 32'(bad), 32'd0);

    // Reset in READ idx 2 aborts the request.
    @(negedge clk);
    bus.start         = 1'b1;
    bus.current_state = 6'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort pre_addr", 32'(bus.q_rd_addr), 32'({6'd7, 2'd2}));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort next_action", 32'(bus.next_action), 32'd0);
    check("abort explored", 32'(bus.explored), 32'd0);
    check("abort action_valid", 32'(bus.action_valid), 32'd0);
    check("abort q_rd_en", 32'(bus.q_rd_en), 32'd0);
    check("abort q_rd_addr", 32'(bus.q_rd_addr), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    nv = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.action_valid) nv++;
    end
    check("abort no_valid", 32'(nv), 32'd0);
    // Fresh request after reset: LFSR prediction restarts from the seed.
    run_req(6'd7, 8'd255, 1'b0, 6'd0, "post_rst");

    // Full exploration sweep.
    for (int i = 0; i < 256; i++)
      run_req(6'(i), 8'd255, 1'b0, 6'd0, $sformatf("eps255_%0d", i));

    // Mid epsilon, random states.
    for (int i = 0; i < 8; i++)
      run_req(6'($urandom_range(63)), 8'd128, 1'b0, 6'd0, $sformatf("eps128_%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
